// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 size codes,
// FSM state encoding and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data byte-lane selection and sign/zero extension.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[8*byte_off_i +: 8];
    half_v = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {24'h0, byte_v};
      F3_HU:   data_o = {16'h0, half_v};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Multi-cycle RV32I load/store unit with an integrated little-endian data
// memory, configurable wait latency and access error reporting.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_BYTES = 131072,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wd_in,
  output logic        stall_out,
  output logic        done_out,
  output logic [31:0] rdata_out,
  output logic        err_out
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("lsu_mem: only DATA_WIDTH=32 is supported");
  end
  if (LATENCY > 15) begin : g_bad_latency
    $error("lsu_mem: LATENCY must be in 0..15");
  end

  lsu_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wd_q, rdata_q;
  logic [31:0] mem_q [DEPTH_BYTES/4];

  // With LATENCY=0 the commit edge is the accept edge, so the access fields
  // come straight from the inputs in IDLE and from the latches afterwards.
  logic        acc_we, acc_err, illegal, misal, oor, commit;
  logic [2:0]  acc_f3, acc_size;
  logic [31:0] acc_addr, acc_wd, off, ext_data, wdata_sh;
  logic [3:0]  be;
  logic [IDX_W-3:0] widx;

  always_comb begin
    acc_we   = (state_q == IDLE) ? we_in     : we_q;
    acc_f3   = (state_q == IDLE) ? funct3_in : f3_q;
    acc_addr = (state_q == IDLE) ? addr_in   : addr_q;
    acc_wd   = (state_q == IDLE) ? wd_in     : wd_q;
    acc_size = size_bytes(acc_f3);
    illegal  = acc_we ? !(acc_f3 inside {F3_B, F3_H, F3_W})
                      : (acc_f3 inside {3'b011, 3'b110, 3'b111});
    misal    = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
               ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
    off      = acc_addr - BASE_ADDR;
    oor      = (acc_addr < BASE_ADDR) ||
               (({1'b0, off} + 33'(acc_size)) > 33'(DEPTH_BYTES));
    acc_err  = illegal || misal || oor;
    widx     = off[IDX_W-1:2];
    wdata_sh = acc_wd << {acc_addr[1:0], 3'b000};
    case (acc_f3[1:0])
      2'b00:   be = 4'b0001 << acc_addr[1:0];
      2'b01:   be = 4'b0011 << acc_addr[1:0];
      default: be = 4'b1111;
    endcase
  end

  lsu_extend u_extend (
    .word_i     (mem_q[widx]),
    .byte_off_i (acc_addr[1:0]),
    .funct3_i   (acc_f3),
    .data_o     (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (req_in) begin
        if (LATENCY == 0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = DONE;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_in) begin
        we_q   <= we_in;
        f3_q   <= funct3_in;
        addr_q <= addr_in;
        wd_q   <= wd_in;
      end
      if (commit) begin
        err_q <= acc_err;
        if (acc_err)     rdata_q <= '0;
        else if (!acc_we) rdata_q <= ext_data;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (commit && acc_we && !acc_err && !rst_in) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign done_out  = (state_q == DONE);
  assign err_out   = done_out && err_q;
  assign rdata_out = rdata_q;
  assign stall_out = req_in && (state_q != DONE);

endmodule

// File: tb/tb_lsu_mem.sv
// Directed-vector bench for lsu_mem: LATENCY=2 main instance plus a LATENCY=0
// instance for single-cycle turnaround timing.
module tb_lsu_mem;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0, wd = '0;
  logic        stall, done, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [2:0]  f30 = '0;
  logic [31:0] addr0 = '0, wd0 = '0;
  logic        stall0, done0, err0;
  logic [31:0] rdata0;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem #(.LATENCY(2)) u_dut (
    .clk_in(clk), .rst_in(rst), .req_in(req), .we_in(we), .funct3_in(f3),
    .addr_in(addr), .wd_in(wd), .stall_out(stall), .done_out(done),
    .rdata_out(rdata), .err_out(err)
  );

  lsu_mem #(.LATENCY(0)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .req_in(req0), .we_in(we0), .funct3_in(f30),
    .addr_in(addr0), .wd_in(wd0), .stall_out(stall0), .done_out(done0),
    .rdata_out(rdata0), .err_out(err0)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] r, input logic e);
    vec_t v;
    v.we = w; v.f3 = f; v.addr = a; v.wd = d; v.rd = r; v.err = e;
    return v;
  endfunction

  // Called one delta after a posedge with the DUT in IDLE; returns likewise.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0, stl = 0;
    bit seen = 0;
    req = 1'b1; we = v.we; f3 = v.f3; addr = v.addr; wd = v.wd;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        if (stall) stl++;
        cyc++;
      end
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd3);
    chk({tag, "_stall"}, 32'(stl), 32'd3);
    chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, v.err});
    if (!v.we || v.err) chk({tag, "_rdata"}, rdata, v.rd);
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back(mk(1, 3'b010, 32'h0001_0000, 32'hDEADBEEF, 32'h0, 0));
    vt.push_back(mk(0, 3'b010, 32'h0001_0000, 32'h0, 32'hDEADBEEF, 0));
    vt.push_back(mk(0, 3'b000, 32'h0001_0003, 32'h0, 32'hFFFFFFDE, 0));
    vt.push_back(mk(0, 3'b100, 32'h0001_0003, 32'h0, 32'h000000DE, 0));
    vt.push_back(mk(0, 3'b001, 32'h0001_0000, 32'h0, 32'hFFFFBEEF, 0));
    vt.push_back(mk(0, 3'b101, 32'h0001_0002, 32'h0, 32'h0000DEAD, 0));
    vt.push_back(mk(1, 3'b000, 32'h0001_0001, 32'h12345655, 32'h0, 0));
    vt.push_back(mk(0, 3'b010, 32'h0001_0000, 32'h0, 32'hDEAD55EF, 0));
    vt.push_back(mk(0, 3'b010, 32'h0001_0002, 32'h0, 32'h0, 1));
    vt.push_back(mk(1, 3'b001, 32'h0001_0001, 32'h0000FFFF, 32'h0, 1));
    vt.push_back(mk(0, 3'b010, 32'h0001_0000, 32'h0, 32'hDEAD55EF, 0));
    vt.push_back(mk(0, 3'b010, 32'h0000_FFFC, 32'h0, 32'h0, 1));
    vt.push_back(mk(0, 3'b001, 32'h0001_0002, 32'h0, 32'hFFFFDEAD, 0));
    vt.push_back(mk(0, 3'b000, 32'h0001_0001, 32'h0, 32'h00000055, 0));
    vt.push_back(mk(0, 3'b000, 32'h0001_0000, 32'h0, 32'hFFFFFFEF, 0));
    vt.push_back(mk(1, 3'b010, 32'h0002_FFFC, 32'h01020304, 32'h0, 0));
    vt.push_back(mk(0, 3'b010, 32'h0002_FFFC, 32'h0, 32'h01020304, 0));
    vt.push_back(mk(0, 3'b001, 32'h0002_FFFE, 32'h0, 32'h00000102, 0));
    vt.push_back(mk(0, 3'b000, 32'h0002_FFFF, 32'h0, 32'h00000001, 0));
    vt.push_back(mk(0, 3'b010, 32'h0003_0000, 32'h0, 32'h0, 1));
    vt.push_back(mk(0, 3'b000, 32'h0003_0000, 32'h0, 32'h0, 1));
    vt.push_back(mk(0, 3'b011, 32'h0001_0000, 32'h0, 32'h0, 1));
    vt.push_back(mk(1, 3'b100, 32'h0001_0000, 32'hFFFFFFFF, 32'h0, 1));
    vt.push_back(mk(0, 3'b010, 32'h0001_0000, 32'h0, 32'hDEAD55EF, 0));
    vt.push_back(mk(1, 3'b010, 32'h0001_0010, 32'h11223344, 32'h0, 0));
    vt.push_back(mk(0, 3'b010, 32'h0001_0010, 32'h0, 32'h11223344, 0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i]) run_vec(vt[i], $sformatf("v%0d", i));

    // reset mid-WAIT discards the pending store
    req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h0001_0010; wd = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstw_done", {31'b0, done}, 32'd0);
    chk("rstw_err", {31'b0, err}, 32'd0);
    chk("rstw_rdata", rdata, 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(mk(0, 3'b010, 32'h0001_0010, 32'h0, 32'h11223344, 0), "rstw_lw");

    // req dropped and inputs changed during WAIT: store still commits as accepted
    begin
      int cyc = 0;
      bit seen = 0;
      req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h0001_0020; wd = 32'hA5A5A5A5;
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0; addr = 32'h0001_0000; wd = 32'h0;
      while (!seen && cyc < 20) begin
        @(negedge clk);
        if (done) seen = 1;
        else cyc++;
      end
      chk("drop_lat", 32'(cyc), 32'd2);
      @(posedge clk); #1;
    end
    run_vec(mk(0, 3'b010, 32'h0001_0020, 32'h0, 32'hA5A5A5A5, 0), "drop_lw");
    run_vec(mk(0, 3'b010, 32'h0001_0000, 32'h0, 32'hDEAD55EF, 0), "drop_lw0");

    // LATENCY=0: completion in the next cycle, back-to-back every 2 cycles
    req0 = 1'b1; we0 = 1'b1; f30 = 3'b010; addr0 = 32'h0001_0000; wd0 = 32'h0BADF00D;
    @(negedge clk);
    chk("l0_sw_acc_done", {31'b0, done0}, 32'd0);
    chk("l0_sw_acc_stall", {31'b0, stall0}, 32'd1);
    @(negedge clk);
    chk("l0_sw_done", {31'b0, done0}, 32'd1);
    chk("l0_sw_stall", {31'b0, stall0}, 32'd0);
    chk("l0_sw_err", {31'b0, err0}, 32'd0);
    we0 = 1'b0;
    @(negedge clk);
    chk("l0_lw_acc_done", {31'b0, done0}, 32'd0);
    @(negedge clk);
    chk("l0_lw_done", {31'b0, done0}, 32'd1);
    chk("l0_lw_rdata", rdata0, 32'h0BADF00D);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("l0_b2b%0d", k), {31'b0, done0}, {31'b0, k[0]});
    end
    req0 = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
